stream_nary_add: RTL and testbench

STREAM_NARY_ADD -- requirements
Module: stream_nary_add

---
 rtl/stream_nary_add.sv | 183 ++++++++++++++++++
 tb/tb_stream_nary_add.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_nary_add.sv
// stream_nary_add: joins N_IN token streams and combines their payloads (sum or unsigned max) into one stream.
// Latency: a fire in cycle t makes its token visible on out_din/out_write in cycle t+1.
// Backpressure: out_full_n low stalls the output FIFO; no input is read while the FIFO holds DEPTH tokens.
module stream_nary_add #(
   parameter int DATA_W = 32,
   parameter int N_IN   = 2,
   parameter int DEPTH  = 4,
   parameter int MODE   = 0
) (
   input  logic                        ap_clk,
   input  logic                        ap_rst,
   input  logic                        ap_start,
   output logic                        ap_ready,
   output logic                        ap_done,
   output logic                        ap_idle,
   input  logic [N_IN*(DATA_W+1)-1:0]  in_dout,
   input  logic [N_IN-1:0]             in_empty_n,
   output logic [N_IN-1:0]             in_read,
   output logic [DATA_W:0]             out_din,
   input  logic                        out_full_n,
   output logic                        out_write,
   output logic [31:0]                 elem_count,
   output logic                        eot_err
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam int TW = DATA_W + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   // output FIFO storage; the head entry drives out_din directly from flops
   logic [TW-1:0]     r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [CW-1:0]     r_count;

   logic              w_fifo_full;
   logic              w_fifo_empty;
   logic              w_push;
   logic              w_pop;
   logic [TW-1:0]     w_push_dat;

   logic [DATA_W-1:0] w_result;
   logic [N_IN-1:0]   w_eot;
   logic              w_all_vld;
   logic              w_all_eot;
   logic              w_any_eot;
   logic              w_fire;

   assign w_fifo_full  = (r_count == CW'(DEPTH));
   assign w_fifo_empty = (r_count == '0);

   // per-channel EOT extraction and the payload combine (sum wraps at DATA_W bits)
   always_comb begin
      w_result = '0;
      w_eot    = '0;
      for (int k = 0; k < N_IN; k++) begin
         w_eot[k] = in_dout[k*TW + DATA_W];
         if (MODE == 1) begin
            if (in_dout[k*TW +: DATA_W] > w_result) begin
               w_result = in_dout[k*TW +: DATA_W];
            end
         end else begin
            w_result = w_result + in_dout[k*TW +: DATA_W];
         end
      end
   end

   assign w_all_vld = &in_empty_n;
   assign w_all_eot = &w_eot;
   assign w_any_eot = |w_eot;

   // a full FIFO blocks the fire even if a pop happens in the same cycle
   assign w_fire = (r_state == S_RUN) && w_all_vld && !w_fifo_full;

   // any EOT (matched or not) closes the transfer with a single close token
   assign w_push_dat = w_any_eot ? {1'b1, {DATA_W{1'b0}}} : {1'b0, w_result};
   assign w_push     = w_fire;
   assign w_pop      = !w_fifo_empty && out_full_n;

   assign out_write  = w_pop;
   assign out_din    = r_mem[r_rd_ptr];

   // FIFO pointers, occupancy and storage; reset empties and zeroes everything
   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_dat;
            r_wr_ptr        <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // control state register
   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // next-state and handshake outputs; in_read is all-or-nothing on a fire
   always_comb begin
      w_state_nxt = r_state;
      ap_ready    = 1'b0;
      ap_done     = 1'b0;
      ap_idle     = 1'b0;
      in_read     = '0;
      case (r_state)
         S_IDLE: begin
            ap_idle = 1'b1;
            if (ap_start && !ap_rst) begin
               ap_ready    = 1'b1;
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (w_fire) begin
               in_read = '1;
               if (w_any_eot) begin
                  w_state_nxt = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (w_fifo_empty) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            ap_done     = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // run statistics: cleared when a start is accepted, count saturates
   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         elem_count <= '0;
         eot_err    <= 1'b0;
      end else if (r_state == S_IDLE && ap_start) begin
         elem_count <= '0;
         eot_err    <= 1'b0;
      end else begin
         if (w_pop && !out_din[DATA_W] && (elem_count != 32'hFFFF_FFFF)) begin
            elem_count <= elem_count + 32'd1;
         end
         if (w_fire && w_any_eot && !w_all_eot) begin
            eot_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_stream_nary_add.sv
// tb_stream_nary_add: directed checks of stream_nary_add in sum mode (2 inputs) and max mode (4 inputs).
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure: out_full_n is held low in one scenario to fill the output FIFO.
module tb_stream_nary_add;

   localparam int W0 = 32;
   localparam int N0 = 2;
   localparam int W1 = 8;
   localparam int N1 = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   // sum-mode instance
   logic                 start0, ready0, done0, idle0, full_n0, wr0, err0;
   logic [N0*(W0+1)-1:0] din0;
   logic [N0-1:0]        vld0, rd0, rd0_q;
   logic [W0:0]          dout0;
   logic [31:0]          cnt0;

   // max-mode instance
   logic                 start1, ready1, done1, idle1, full_n1, wr1, err1;
   logic [N1*(W1+1)-1:0] din1;
   logic [N1-1:0]        vld1, rd1, rd1_q;
   logic [W1:0]          dout1;
   logic [31:0]          cnt1;

   stream_nary_add #(.DATA_W(W0), .N_IN(N0), .DEPTH(4), .MODE(0)) dut0 (
      .ap_clk(clk), .ap_rst(rst), .ap_start(start0), .ap_ready(ready0),
      .ap_done(done0), .ap_idle(idle0), .in_dout(din0), .in_empty_n(vld0),
      .in_read(rd0), .out_din(dout0), .out_full_n(full_n0), .out_write(wr0),
      .elem_count(cnt0), .eot_err(err0)
   );

   stream_nary_add #(.DATA_W(W1), .N_IN(N1), .DEPTH(4), .MODE(1)) dut1 (
      .ap_clk(clk), .ap_rst(rst), .ap_start(start1), .ap_ready(ready1),
      .ap_done(done1), .ap_idle(idle1), .in_dout(din1), .in_empty_n(vld1),
      .in_read(rd1), .out_din(dout1), .out_full_n(full_n1), .out_write(wr1),
      .elem_count(cnt1), .eot_err(err1)
   );

   // stimulus tables and read pointers per channel
   logic [W0:0] s0 [N0][16];
   int          len0 [N0];
   int          ptr0 [N0];
   logic [W1:0] s1 [N1][16];
   int          len1 [N1];
   int          ptr1 [N1];

   logic [W0:0] got0[$];
   logic [W0:0] exp0[$];
   logic [W1:0] got1[$];
   logic [W1:0] exp1[$];

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int fires0 = 0;
   int dones0 = 0;
   int dones1 = 0;
   int first_fire0 = -1;
   int first_wr0 = -1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // source model: advance a channel after the edge at which the DUT read it
   always @(posedge clk) begin
      #1;
      for (int k = 0; k < N0; k++) begin
         if (rd0_q[k]) ptr0[k] = ptr0[k] + 1;
         vld0[k] = (ptr0[k] < len0[k]);
         din0[k*(W0+1) +: W0+1] = (ptr0[k] < len0[k]) ? s0[k][ptr0[k]] : '0;
      end
      for (int k = 0; k < N1; k++) begin
         if (rd1_q[k]) ptr1[k] = ptr1[k] + 1;
         vld1[k] = (ptr1[k] < len1[k]);
         din1[k*(W1+1) +: W1+1] = (ptr1[k] < len1[k]) ? s1[k][ptr1[k]] : '0;
      end
      rd0_q = '0;
      rd1_q = '0;
   end

   // sink model: record transfers, fires and done pulses away from the edge
   always @(negedge clk) begin
      cyc++;
      rd0_q = rd0;
      rd1_q = rd1;
      if (wr0) begin
         got0.push_back(dout0);
         if (first_wr0 < 0) first_wr0 = cyc;
      end
      if (&rd0) begin
         fires0++;
         if (first_fire0 < 0) first_fire0 = cyc;
      end
      if (done0) dones0++;
      if (wr1) got1.push_back(dout1);
      if (done1) dones1++;
   end

   task automatic clear0();
      for (int k = 0; k < N0; k++) begin
         len0[k] = 0;
         ptr0[k] = 0;
      end
      got0.delete();
      exp0.delete();
      fires0 = 0;
      dones0 = 0;
      first_fire0 = -1;
      first_wr0 = -1;
   endtask

   task automatic start0_pulse();
      @(posedge clk);
      #1 start0 = 1'b1;
      @(negedge clk);
      check("ready0_pulse", 64'(ready0), 64'd1);
      @(posedge clk);
      #1 start0 = 1'b0;
   endtask

   task automatic wait_done0(input string tag, input int budget);
      for (int i = 0; i < budget && dones0 < 1; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      check({tag, "_done_once"}, 64'(dones0), 64'd1);
      check({tag, "_idle"}, 64'(idle0), 64'd1);
   endtask

   task automatic cmp_got0(input string tag);
      check({tag, "_len"}, 64'(got0.size()), 64'(exp0.size()));
      foreach (exp0[i]) begin
         check($sformatf("%s_tok%0d", tag, i),
               (i < got0.size()) ? 64'(got0[i]) : {64{1'bx}}, 64'(exp0[i]));
      end
   endtask

   localparam logic [W0:0] CLOSE0 = {1'b1, {W0{1'b0}}};
   localparam logic [W1:0] CLOSE1 = {1'b1, {W1{1'b0}}};

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      start0 = 1'b0; start1 = 1'b0;
      full_n0 = 1'b1; full_n1 = 1'b1;
      vld0 = '0; vld1 = '0; din0 = '0; din1 = '0;
      rd0_q = '0; rd1_q = '0;
      clear0();
      for (int k = 0; k < N1; k++) begin
         len1[k] = 0;
         ptr1[k] = 0;
      end

      // reset values, sampled before any clock edge
      #3;
      check("rst_idle", 64'(idle0), 64'd1);
      check("rst_ready", 64'(ready0), 64'd0);
      check("rst_done", 64'(done0), 64'd0);
      check("rst_read", 64'(rd0), 64'd0);
      check("rst_write", 64'(wr0), 64'd0);
      check("rst_dout", 64'(dout0), 64'd0);
      check("rst_count", 64'(cnt0), 64'd0);
      check("rst_err", 64'(err0), 64'd0);
      #10 rst = 1'b0;

      // 1..5 on both channels, then EOT
      clear0();
      for (int i = 0; i < 5; i++) begin
         s0[0][i] = {1'b0, 32'(i + 1)};
         s0[1][i] = {1'b0, 32'(i + 1)};
         exp0.push_back({1'b0, 32'(2 * (i + 1))});
      end
      s0[0][5] = CLOSE0; s0[1][5] = CLOSE0;
      len0[0] = 6; len0[1] = 6;
      exp0.push_back(CLOSE0);
      start0_pulse();
      wait_done0("basic", 100);
      cmp_got0("basic");
      check("basic_count", 64'(cnt0), 64'd5);
      check("basic_err", 64'(err0), 64'd0);
      check("basic_latency", 64'(first_wr0 - first_fire0), 64'd1);

      // sum wraps modulo 2^32
      clear0();
      s0[0][0] = {1'b0, 32'hFFFF_FFFF};
      s0[1][0] = {1'b0, 32'h0000_0002};
      s0[0][1] = CLOSE0; s0[1][1] = CLOSE0;
      len0[0] = 2; len0[1] = 2;
      exp0.push_back({1'b0, 32'h0000_0001});
      exp0.push_back(CLOSE0);
      start0_pulse();
      wait_done0("wrap", 100);
      cmp_got0("wrap");
      check("wrap_count", 64'(cnt0), 64'd1);

      // output blocked: only DEPTH fires, then full drain in order
      clear0();
      full_n0 = 1'b0;
      for (int i = 0; i < 6; i++) begin
         s0[0][i] = {1'b0, 32'(i + 1)};
         s0[1][i] = {1'b0, 32'd100};
         exp0.push_back({1'b0, 32'(101 + i)});
      end
      s0[0][6] = CLOSE0; s0[1][6] = CLOSE0;
      len0[0] = 7; len0[1] = 7;
      exp0.push_back(CLOSE0);
      start0_pulse();
      repeat (12) @(negedge clk);
      check("bp_fires", 64'(fires0), 64'd4);
      check("bp_read_low", 64'(rd0), 64'd0);
      check("bp_write_low", 64'(wr0), 64'd0);
      check("bp_no_out", 64'(got0.size()), 64'd0);
      @(posedge clk);
      #1 full_n0 = 1'b1;
      wait_done0("bp", 100);
      cmp_got0("bp");
      check("bp_count", 64'(cnt0), 64'd6);

      // EOT on channel 0 while channel 1 still carries data
      clear0();
      s0[0][0] = {1'b0, 32'd5};  s0[0][1] = CLOSE0;
      s0[1][0] = {1'b0, 32'd7};  s0[1][1] = {1'b0, 32'd8};  s0[1][2] = CLOSE0;
      len0[0] = 2; len0[1] = 3;
      exp0.push_back({1'b0, 32'd12});
      exp0.push_back(CLOSE0);
      start0_pulse();
      wait_done0("mixed", 100);
      cmp_got0("mixed");
      check("mixed_err", 64'(err0), 64'd1);
      check("mixed_count", 64'(cnt0), 64'd1);
      check("mixed_ch0_used", 64'(ptr0[0]), 64'd2);
      check("mixed_ch1_used", 64'(ptr0[1]), 64'd2);

      // reset after two outputs, then a clean restart
      clear0();
      for (int i = 0; i < 5; i++) begin
         s0[0][i] = {1'b0, 32'(10 * (i + 1))};
         s0[1][i] = {1'b0, 32'd1};
      end
      s0[0][5] = CLOSE0; s0[1][5] = CLOSE0;
      len0[0] = 6; len0[1] = 6;
      start0_pulse();
      for (int i = 0; i < 50 && got0.size() < 2; i++) @(negedge clk);
      check("rstmid_two_out", 64'(got0.size()), 64'd2);
      check("rstmid_first", 64'(got0[0]), 64'({1'b0, 32'd11}));
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("rstmid_idle", 64'(idle0), 64'd1);
      check("rstmid_write", 64'(wr0), 64'd0);
      check("rstmid_read", 64'(rd0), 64'd0);
      check("rstmid_dout", 64'(dout0), 64'd0);
      check("rstmid_count", 64'(cnt0), 64'd0);
      check("rstmid_done", 64'(done0), 64'd0);
      clear0();
      @(negedge clk);
      #2 rst = 1'b0;
      repeat (6) @(negedge clk);
      check("rstmid_quiet", 64'(got0.size()), 64'd0);
      for (int i = 0; i < 5; i++) begin
         s0[0][i] = {1'b0, 32'(10 * (i + 1))};
         s0[1][i] = {1'b0, 32'd1};
         exp0.push_back({1'b0, 32'(10 * (i + 1) + 1)});
      end
      s0[0][5] = CLOSE0; s0[1][5] = CLOSE0;
      len0[0] = 6; len0[1] = 6;
      exp0.push_back(CLOSE0);
      start0_pulse();
      wait_done0("restart", 100);
      cmp_got0("restart");
      check("restart_count", 64'(cnt0), 64'd5);

      // unsigned max over four channels
      s1[0][0] = 9'd3;   s1[1][0] = 9'd9;  s1[2][0] = 9'd1;   s1[3][0] = 9'd7;
      s1[0][1] = 9'd128; s1[1][1] = 9'd17; s1[2][1] = 9'd255; s1[3][1] = 9'd0;
      for (int k = 0; k < N1; k++) begin
         s1[k][2] = CLOSE1;
         len1[k] = 3;
      end
      exp1.push_back(9'h009);
      exp1.push_back(9'h0FF);
      exp1.push_back(CLOSE1);
      @(posedge clk);
      #1 start1 = 1'b1;
      @(negedge clk);
      check("max_ready", 64'(ready1), 64'd1);
      @(posedge clk);
      #1 start1 = 1'b0;
      for (int i = 0; i < 100 && dones1 < 1; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      check("max_done_once", 64'(dones1), 64'd1);
      check("max_len", 64'(got1.size()), 64'(exp1.size()));
      foreach (exp1[i]) begin
         check($sformatf("max_tok%0d", i),
               (i < got1.size()) ? 64'(got1[i]) : {64{1'bx}}, 64'(exp1[i]));
      end
      check("max_count", 64'(cnt1), 64'd2);
      check("max_err", 64'(err1), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
